sext_arbiter: RTL and testbench
===============================

// Module: sext_arbiter
// PURPOSE
//   Shares one sign/zero-extension datapath between N_REQ requesters.
//   - Round-robin arbitration; one grant per cycle.
//   - Each requester presents an IN_W-bit value plus a signed flag.
//   - Winner's value is extended to OUT_W and registered into a single output slot
//     with a valid/ready handshake, tagged with the requester ID.
//   - Sits between narrow-operand producers (load/imm units) and the wide ALU.
// PARAMETERS
//   N_REQ  4   number of requesters (>=2)
//   IN_W   8   input operand width
//   OUT_W  32  output width; elaboration error if IN_W > OUT_W
// PORTS
//   clk        in   1                clock, rising edge
//   areset_n   in   1                asynchronous reset, active-low
//   req_valid  in   N_REQ            requester i has an operand
//   req_data   in   N_REQ*IN_W       operand i at [i*IN_W +: IN_W]
//   req_signed in   N_REQ            1 = sign-extend, 0 = zero-extend
//   req_ready  out  N_REQ            one-hot grant; transfer when valid&ready
//   out_valid  out  1                output slot holds a result
//   out_data   out  OUT_W            extended result
//   out_id     out  $clog2(N_REQ)    index of originating requester
//   out_ready  in   1                consumer accepts result
// BEHAVIOUR
//   - Reset (async, areset_n=0) clears: out_valid=0, out_data=0, out_id=0, rr_ptr=0.
//     req_ready is combinational, so it is 0 while out_valid=0 and no req_valid is set.
//   - Reset mid-operation drops any held result immediately; no replay.
//   - Slot FSM:
//     - EMPTY(out_valid=0) -> FULL on grant.
//     - FULL -> EMPTY when out_ready=1 and no new grant.
//     - FULL -> FULL on out_ready=1 with a simultaneous grant (pass-through refill).
//   - slot_free = !out_valid || out_ready.
//     - Grant only when slot_free and |req_valid.
//     - Winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod N_REQ.
//   - req_ready:
//     - Combinational: one-hot on the winner and gated by slot_free.
//     - All-zero when no grant.
//     - Never depends on req_data.
//   - On grant:
//     - Next cycle out_valid=1 and out_id=winner (latency 1).
//     - out_data = {{(OUT_W-IN_W){req_signed&data[IN_W-1]}}, data}.
//     - rr_ptr <= winner+1; wraps N_REQ-1 -> 0. rr_ptr unchanged when there is no grant.
//   - Backpressure (out_valid=1, out_ready=0):
//     - out_data and out_id are held stable.
//     - All req_ready=0.
//   - Throughput: 1 result/cycle with out_ready held high.
//   - Fairness: a continuously valid requester is granted within N_REQ grants.
//   - IN_W == OUT_W is legal: data passes through unchanged.
// CONFIGURATION
//   SEXT_ARB_PERF_EN defined:
//   - Adds output perf_xfer_cnt[31:0]: increments on each out_valid&out_ready.
//   - Adds output perf_stall_cnt[31:0]: increments each cycle out_valid&!out_ready.
//   - Both saturate at 32'hFFFF_FFFF and reset to 0 asynchronously.
//   SEXT_ARB_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//   - Package sext_arb_pkg:
//     - slot_state_e {EMPTY, FULL}.
//     - Function id_w(n) = $clog2(n) with a min of 1.
//     - Localparam PERF_CNT_W = 32.
//   - Sub-module sext_rr_arbiter (N_REQ):
//     - Inputs: req vector, rr_ptr, enable.
//     - Outputs: one-hot grant and encoded index; combinational.
//   - Top module holds rr_ptr, the output register, extension logic and optional counters.
// TESTING  (N_REQ=4, IN_W=8, OUT_W=32)
//   1. Hold areset_n=0 with req_valid=4'hF
//      -> out_valid=0, out_data=0, out_id=0, req_ready=0.
//      First grant after release goes to id 0.
//   2. req0 data=8'h80 signed=1 -> next cycle out_data=32'hFFFF_FF80, out_id=0.
//      Repeat with signed=0 -> 32'h0000_0080. 8'h7F signed=1 -> 32'h0000_007F.
//   3. req_valid=4'hF held, out_ready=1 -> out_id sequence 0,1,2,3,0,1, one per cycle.
//   4. rr_ptr=3, req_valid=4'b1010 -> grants 3 then 1.
//      out_ready=0 for 3 cycles -> out_data/out_id stable, req_ready=0.
//      Release -> next grant in the same cycle.
//   5. areset_n pulsed low while out_valid=1, out_ready=0
//      -> out_valid falls without waiting for clk.
//      No stale result appears after release.
//   6. SEXT_ARB_PERF_EN build: 5 transfers plus 3 stall cycles
//      -> perf_xfer_cnt=5, perf_stall_cnt=3. Preloaded max value does not wrap.

Source files
------------

// File: rtl/sext_arb_pkg.sv
// Shared types and helpers for the sign/zero-extension arbiter.
//   slot_state_e : occupancy of the single output slot
//   id_w()       : requester-index width, never narrower than one bit
//   PERF_CNT_W   : width of the optional performance counters
package sext_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    localparam int PERF_CNT_W = 32;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sext_rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req       in   N_REQ   request vector
//   rr_ptr    in   ID_W    index that has highest priority this cycle
//   enable    in   1       grant allowed (output slot can take a result)
//   grant     out  N_REQ   one-hot grant, all-zero when disabled or idle
//   grant_id  out  ID_W    encoded winner (valid whenever any req is set)
//   grant_any out  1       a grant is issued this cycle
import sext_arb_pkg::*;

module sext_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_any
);

    logic found;

    // Walk rr_ptr, rr_ptr+1, ... (mod N_REQ) and keep the first hit.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                grant_id = ID_W'(idx);
            end
        end
    end

    assign grant_any = enable && found;

    always_comb begin
        grant = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant[i] = grant_any && (grant_id == ID_W'(i));
        end
    end

endmodule

// File: rtl/sext_arbiter.sv
// Shares one sign/zero-extension datapath between N_REQ requesters.
// Round-robin picks one requester per cycle; its IN_W operand is extended to
// OUT_W and registered into a single output slot with a valid/ready handshake.
// Optional feature macro: SEXT_ARB_PERF_EN (adds transfer/stall counters).
// Ports:
//   clk            in   1            rising-edge clock
//   areset_n       in   1            asynchronous active-low reset
//   req_valid      in   N_REQ        requester i has an operand
//   req_data       in   N_REQ*IN_W   operand i at [i*IN_W +: IN_W]
//   req_signed     in   N_REQ        1 = sign-extend, 0 = zero-extend
//   req_ready      out  N_REQ        one-hot grant (combinational)
//   out_valid      out  1            output slot holds a result
//   out_data       out  OUT_W        extended result
//   out_id         out  ID_W         originating requester
//   out_ready      in   1            consumer accepts result
//   perf_xfer_cnt  out  32           (SEXT_ARB_PERF_EN) saturating transfer count
//   perf_stall_cnt out  32           (SEXT_ARB_PERF_EN) saturating stall-cycle count
//
// Slot states:
//   state | meaning
//   EMPTY | no result held, out_valid=0
//   FULL  | result held in out_data/out_id, out_valid=1
import sext_arb_pkg::*;

module sext_arbiter #(
    parameter int N_REQ = 4,
    parameter int IN_W  = 8,
    parameter int OUT_W = 32
) (
    input  logic                    clk,
    input  logic                    areset_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*IN_W-1:0]   req_data,
    input  logic [N_REQ-1:0]        req_signed,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [OUT_W-1:0]        out_data,
    output logic [id_w(N_REQ)-1:0]  out_id,
    input  logic                    out_ready
`ifdef SEXT_ARB_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0]   perf_xfer_cnt,
    output logic [PERF_CNT_W-1:0]   perf_stall_cnt
`endif
);

    localparam int ID_W = id_w(N_REQ);

    generate
        if (IN_W > OUT_W) begin : g_bad_width
            $error("sext_arbiter: IN_W must not exceed OUT_W");
        end
        if (N_REQ < 2) begin : g_bad_nreq
            $error("sext_arbiter: N_REQ must be at least 2");
        end
    endgenerate

    slot_state_e      state;
    logic [ID_W-1:0]  rr_ptr;
    logic             slot_free;
    logic             grant_en;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             grant_any;
    logic [IN_W-1:0]  win_data;
    logic             win_signed;
    logic [OUT_W-1:0] ext_data;

    assign out_valid = (state == FULL);
    assign slot_free = !out_valid || out_ready;
    // No handshake is offered while reset is asserted, even though the slot reads empty.
    assign grant_en  = slot_free && areset_n;

    sext_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .enable    (grant_en),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    assign req_ready = grant;

    always_comb begin
        win_data   = '0;
        win_signed = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                win_data   = req_data[i*IN_W +: IN_W];
                win_signed = req_signed[i];
            end
        end
    end

    // Equal widths need no extension; a zero-width replication is avoided.
    generate
        if (OUT_W == IN_W) begin : g_pass
            assign ext_data = win_data;
        end else begin : g_ext
            assign ext_data = {{(OUT_W-IN_W){win_signed & win_data[IN_W-1]}}, win_data};
        end
    endgenerate

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_id   <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                EMPTY: if (grant_any) state <= FULL;
                FULL:  if (out_ready && !grant_any) state <= EMPTY;
                default: state <= EMPTY;
            endcase
            if (grant_any) begin
                out_data <= ext_data;
                out_id   <= grant_id;
                rr_ptr   <= (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

`ifdef SEXT_ARB_PERF_EN
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            perf_xfer_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (out_valid && out_ready && (perf_xfer_cnt != '1))
                perf_xfer_cnt <= perf_xfer_cnt + 1'b1;
            if (out_valid && !out_ready && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sext_arbiter.sv
module tb_sext_arbiter;

    logic        clk;
    logic        areset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_signed;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_id;
    logic        out_ready;
`ifdef SEXT_ARB_PERF_EN
    logic [31:0] perf_xfer_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    sext_arbiter #(.N_REQ(4), .IN_W(8), .OUT_W(32)) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_signed (req_signed),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready)
`ifdef SEXT_ARB_PERF_EN
        ,
        .perf_xfer_cnt  (perf_xfer_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  sgn;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [31:0] exp_od;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        areset_n   = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req_signed = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        areset_n = 1'b1;
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [3:0] s, input logic r);
        req_valid  = v;
        req_data   = d;
        req_signed = s;
        out_ready  = r;
        #1;
    endtask

    initial begin
        // rr_ptr starts at 0 after reset; all rows hand-derived in order.
        vecs[0]  = '{4'h1, 32'h0000_0080, 4'h1, 1'b1, 4'h1, 1'b1, 32'hFFFF_FF80, 2'd0};
        vecs[1]  = '{4'h1, 32'h0000_0080, 4'h0, 1'b1, 4'h1, 1'b1, 32'h0000_0080, 2'd0};
        vecs[2]  = '{4'h1, 32'h0000_007F, 4'h1, 1'b1, 4'h1, 1'b1, 32'h0000_007F, 2'd0};
        vecs[3]  = '{4'h0, 32'h0000_0000, 4'h0, 1'b1, 4'h0, 1'b0, 32'h0,         2'd0};
        vecs[4]  = '{4'hF, 32'hF403_8201, 4'hA, 1'b1, 4'h2, 1'b1, 32'hFFFF_FF82, 2'd1};
        vecs[5]  = '{4'hF, 32'hF403_8201, 4'hA, 1'b1, 4'h4, 1'b1, 32'h0000_0003, 2'd2};
        vecs[6]  = '{4'hF, 32'hF403_8201, 4'hA, 1'b1, 4'h8, 1'b1, 32'hFFFF_FFF4, 2'd3};
        vecs[7]  = '{4'hF, 32'hF403_8201, 4'hA, 1'b1, 4'h1, 1'b1, 32'h0000_0001, 2'd0};
        vecs[8]  = '{4'hA, 32'hF403_8201, 4'hA, 1'b0, 4'h0, 1'b1, 32'h0000_0001, 2'd0};
        vecs[9]  = '{4'hA, 32'hF403_8201, 4'hA, 1'b0, 4'h0, 1'b1, 32'h0000_0001, 2'd0};
        vecs[10] = '{4'hA, 32'hF403_8201, 4'hA, 1'b1, 4'h2, 1'b1, 32'hFFFF_FF82, 2'd1};
        vecs[11] = '{4'hA, 32'hF403_8201, 4'hA, 1'b1, 4'h8, 1'b1, 32'hFFFF_FFF4, 2'd3};
        vecs[12] = '{4'h0, 32'hF403_8201, 4'hA, 1'b0, 4'h0, 1'b1, 32'hFFFF_FFF4, 2'd3};
        vecs[13] = '{4'h0, 32'h0000_0000, 4'h0, 1'b1, 4'h0, 1'b0, 32'h0,         2'd0};
        vecs[14] = '{4'h4, 32'h00FF_0000, 4'h0, 1'b0, 4'h4, 1'b1, 32'h0000_00FF, 2'd2};
        vecs[15] = '{4'h4, 32'h00FF_0000, 4'h4, 1'b1, 4'h4, 1'b1, 32'hFFFF_FFFF, 2'd2};

        // Reset held with all requesters valid: nothing offered, outputs cleared.
        areset_n   = 1'b0;
        req_valid  = 4'hF;
        req_data   = 32'h4433_2211;
        req_signed = 4'h0;
        out_ready  = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_id", {30'd0, out_id}, 32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        areset_n = 1'b1;
        #1;
        chk("first_grant_ready", {28'd0, req_ready}, 32'h1);

        // Continuous traffic: one result per cycle in round-robin order.
        begin
            logic [1:0] exp_ids [6];
            exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
            for (int i = 0; i < 6; i++) begin
                tick();
                chk("rr_valid", {31'd0, out_valid}, 32'd1);
                chk($sformatf("rr_id[%0d]", i), {30'd0, out_id}, {30'd0, exp_ids[i]});
            end
        end

        // Table-driven vectors from a fresh reset.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].valid, vecs[i].data, vecs[i].sgn, vecs[i].ordy);
            chk($sformatf("v%0d_req_ready", i), {28'd0, req_ready}, {28'd0, vecs[i].exp_rdy});
            tick();
            chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_ov});
            if (vecs[i].exp_ov) begin
                chk($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_od);
                chk($sformatf("v%0d_out_id", i), {30'd0, out_id}, {30'd0, vecs[i].exp_id});
            end
        end

        // rr_ptr=3 with requesters 1 and 3: grant 3, stall 3 cycles, then 1.
        do_reset();
        drive(4'h4, 32'h0, 4'h0, 1'b1);
        tick();                                   // grant 2 -> rr_ptr=3
        drive(4'h0, 32'h0, 4'h0, 1'b1);
        tick();                                   // drain
        chk("bp_drained", {31'd0, out_valid}, 32'd0);
        drive(4'hA, 32'h5500_AA00, 4'hA, 1'b1);
        chk("bp_grant3_ready", {28'd0, req_ready}, 32'h8);
        tick();
        chk("bp_grant3_id", {30'd0, out_id}, 32'd3);
        chk("bp_grant3_data", out_data, 32'h0000_0055);
        drive(4'hA, 32'h5500_AA00, 4'hA, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_stall_ready", {28'd0, req_ready}, 32'h0);
            tick();
            chk("bp_stall_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_stall_id", {30'd0, out_id}, 32'd3);
            chk("bp_stall_data", out_data, 32'h0000_0055);
        end
        drive(4'hA, 32'h5500_AA00, 4'hA, 1'b1);
        chk("bp_release_ready", {28'd0, req_ready}, 32'h2);
        tick();
        chk("bp_grant1_id", {30'd0, out_id}, 32'd1);
        chk("bp_grant1_data", out_data, 32'hFFFF_FFAA);

        // Async reset while holding a backpressured result.
        drive(4'h0, 32'h0, 4'h0, 1'b0);
        tick();
        chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
        #2;
        areset_n = 1'b0;
        #1;
        chk("ar_async_valid", {31'd0, out_valid}, 32'd0);
        tick();
        #2;
        areset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ar_no_replay", {31'd0, out_valid}, 32'd0);
        end

`ifdef SEXT_ARB_PERF_EN
        do_reset();
        drive(4'h1, 32'h0000_0011, 4'h0, 1'b0);
        tick();                                   // grant, no transfer yet
        for (int i = 0; i < 3; i++) tick();       // 3 stall cycles
        drive(4'h1, 32'h0000_0011, 4'h0, 1'b1);
        for (int i = 0; i < 4; i++) tick();       // 4 transfers with refill
        drive(4'h0, 32'h0, 4'h0, 1'b1);
        tick();                                   // 5th transfer, slot empties
        chk("perf_xfer", perf_xfer_cnt, 32'd5);
        chk("perf_stall", perf_stall_cnt, 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
